// File: rtl/req_buffer_mux_if.sv
// req_buffer_mux_if: flit inputs, arbiter request/grant pair and registered output handshake.
interface req_buffer_mux_if #(parameter int N = 4, parameter int DATA_W = 32);
  localparam int SW = N > 1 ? $clog2(N) : 1;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_ready;
  logic [N-1:0]        req;
  logic [N-1:0]        gnt;
  logic [DATA_W-1:0]   out_data;
  logic [SW-1:0]       out_src;
  logic                out_valid;
  logic                out_ready;
  logic                gnt_err;
  modport slave (
    input  in_data, in_valid, gnt, out_ready,
    output in_ready, req, out_data, out_src, out_valid, gnt_err
  );
  modport master (
    output in_data, in_valid, gnt, out_ready,
    input  in_ready, req, out_data, out_src, out_valid, gnt_err
  );
endinterface

// File: rtl/req_buffer_mux.sv
// req_buffer_mux: per-input flit FIFOs raising arbiter requests, grant pops head into a registered output.
// Define REQ_BUF_GNT_CHECK_EN to reject and flag illegal grants (sticky gnt_err).
module req_buffer_mux #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             rst,
  req_buffer_mux_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = N > 1 ? $clog2(N) : 1;
  logic [DATA_W-1:0] r_mem [N][DEPTH];
  logic [AW-1:0]     r_wp  [N];
  logic [AW-1:0]     r_rp  [N];
  logic [CW-1:0]     r_cnt [N];
  logic [DATA_W-1:0] r_out_data;
  logic [SW-1:0]     r_out_src;
  logic              r_out_valid;
  logic              w_free;
  logic [N-1:0]      w_req;
  logic [N-1:0]      w_push;
  logic [N-1:0]      w_sel;
  logic [SW-1:0]     w_idx;
  // Requests are withheld whenever the output cannot take a flit, since the arbiter rotates on every grant.
  assign w_free = !r_out_valid || bus.out_ready;
  always_comb begin
    w_req  = '0;
    w_push = '0;
    for (int i = 0; i < N; i++) begin
      w_req[i]  = (r_cnt[i] != '0) && w_free;
      w_push[i] = bus.in_valid[i] && (r_cnt[i] != CW'(DEPTH));
    end
  end
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) bus.in_ready[i] = r_cnt[i] != CW'(DEPTH);
  end
`ifdef REQ_BUF_GNT_CHECK_EN
  logic w_bad;
  logic r_gnt_err;
  assign w_bad = ((bus.gnt & (bus.gnt - 1'b1)) != '0) || ((bus.gnt & ~w_req) != '0);
  assign w_sel = w_bad ? '0 : bus.gnt;
  always_ff @(posedge clk) begin
    if (rst) r_gnt_err <= 1'b0;
    else if (w_bad) r_gnt_err <= 1'b1;
  end
  assign bus.gnt_err = r_gnt_err;
`else
  logic [N-1:0] w_hit;
  assign w_hit = bus.gnt & w_req;
  assign w_sel = w_hit & (~w_hit + 1'b1);
  assign bus.gnt_err = 1'b0;
`endif
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) if (w_sel[i]) w_idx = SW'(i);
  end
  always_ff @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < N; i++)
        if (w_push[i]) r_mem[i][r_wp[i]] <= bus.in_data[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
        if (w_sel[i]) r_rp[i] <= r_rp[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_sel[i]);
      end
      if (|w_sel) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[w_idx][r_rp[w_idx]];
        r_out_src   <= w_idx;
      end else if (bus.out_ready) r_out_valid <= 1'b0;
    end
  end
  assign bus.req       = w_req;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_valid = r_out_valid;
endmodule

// File: doc/req_buffer_mux.md
# req_buffer_mux

Per-input request buffer and grant-driven output mux that sits directly upstream of the matrix (least-recently-granted) arbiter in a NetEmulation switch port. It queues flits from N sources in small FIFOs, presents one request bit per non-empty queue to the arbiter, and consumes the arbiter's one-hot grant in the same cycle. On a grant it pops the granted head into a registered output stage with a valid/ready handshake.

## Interface
- N, 4, number of inputs; must match the arbiter's n
- DATA_W, 32, flit width in bits
- DEPTH, 4, entries per input FIFO; power of two, >= 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  N*DATA_W  packed flits, slice i belongs to input i
- in_valid  in  N  input i offers a flit
- in_ready  out  N  input i accepts; equals !full[i]
- req  out  N  request vector to arbiter r
- gnt  in  N  grant vector from arbiter g; combinational from req
- out_data  out  DATA_W  granted flit, registered
- out_src  out  clog2(N)  index of the input that supplied out_data
- out_valid  out  1  output register holds a flit
- out_ready  in  1  downstream accepts the flit
- gnt_err  out  1  sticky illegal-grant flag (see Configuration)

## Operation
- Per input: circular FIFO with rd/wr pointers (clog2(DEPTH) bits, natural wrap) and occupancy count (clog2(DEPTH)+1 bits).
- Push on in_valid[i] && in_ready[i]. Full FIFO refuses push even if popped the same cycle.
- Pop and push on the same FIFO in one cycle: count unchanged, both pointers advance.
- out_free = !out_valid || out_ready.
- req[i] = (count[i] != 0) && out_free. Gating by out_free is mandatory: the arbiter rotates priority on every granted request, so no request may be raised that cannot be served.
- No bypass: a flit pushed into an empty FIFO raises req the following cycle.
- Legal grant: gnt one-hot with gnt[i] && req[i], or gnt == 0. On legal one-hot gnt[i]: pop FIFO i, load out_data = head[i], out_src = i, out_valid = 1.
- Output: if out_valid && out_ready && no grant, out_valid -> 0. Grant and out_ready in the same cycle: new flit replaces old, out_valid stays 1 (back-to-back throughput of 1 flit/cycle).
- While out_valid && !out_ready: out_data, out_src, out_valid held stable; req = 0.
- Reset: all counts and pointers 0, in_ready = all 1 from first cycle after rst, req = 0, out_valid = 0, out_data = 0, out_src = 0, gnt_err = 0. Pushes presented while rst is high are dropped. Reset mid-operation discards all buffered and output flits.

## Timing
- Push at edge t -> req visible after t -> pop and output load at edge t+1 -> out_valid high after t+1. Minimum input-to-output latency 2 cycles.
- req and gnt form one combinational path within a cycle; gnt is sampled at the same edge that pops.
- in_ready depends only on registered count (no combinational path from out_ready).

## Configuration
- REQ_BUF_GNT_CHECK_EN defined: an illegal grant (more than one bit set, or gnt[i] with !req[i]) sets gnt_err at the next edge, sticky until rst; that cycle performs no pop and no output load.
- Undefined: gnt_err tied 0; grant is trusted; the lowest set bit of gnt & req selects the source.

## Test plan
- Reset then push 0xA5 on input 2, out_ready = 1 -> req = 4'b0100 one cycle later, out_data = 0xA5, out_src = 2, out_valid two cycles after push.
- Fill input 0 with 4 flits, out_ready = 0 -> in_ready[0] = 0 after 4th push; req = 0 while output stalled; count stays 4.
- All 4 inputs hold 2 flits, out_ready = 1 with arbiter attached -> 8 consecutive out_valid cycles, each input served once before any is served twice.
- Output stalled with 0x11 for 3 cycles -> out_data/out_src stable, no FIFO pops; release out_ready -> next flit loaded in the same cycle.
- With REQ_BUF_GNT_CHECK_EN, force gnt = 4'b0011 -> gnt_err = 1 next cycle, no pop, out_valid unchanged; rst clears it.
- Assert rst with 3 flits buffered and out_valid = 1 -> next cycle out_valid = 0, req = 0, in_ready = 4'b1111.
